// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and legality helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 > F3_SW);
    else          bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return bad;
  endfunction

  // Only meaningful for legal funct3; the low two bits encode the access size.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/data replication and load byte/half extract with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    wstrb     = '0;
    wdata     = '0;
    load_data = '0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        F3_SW: begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
        default: begin
          wstrb = '0;
          wdata = '0;
        end
      endcase
    end else begin
      case (funct3)
        F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
        F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
        F3_LW:   load_data = rdata;
        F3_LBU:  load_data = {24'd0, byte_sel};
        F3_LHU:  load_data = {16'd0, half_sel};
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: IDLE/REQ/RESP sequencer with capture registers in front of a valid/ready data memory.
// Handshakes: an op moves on a cycle where valid and ready are both high at the rising clock edge; dmem_resp_valid is a one-cycle pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_addr,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_wstrb,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fault_valid,
  output logic                  fault_misalign,
  output logic [1:0]            dbg_state
);

  lsu_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  fault_valid_q, fault_valid_d;
  logic                  fault_misalign_q, fault_misalign_d;

  logic [3:0]            lane_wstrb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;

  lsu_align u_align (
    .is_store   (is_store_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (store_data_q),
    .rdata      (dmem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_d          = state_q;
    is_store_d       = is_store_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    store_data_d     = store_data_q;
    rd_d             = rd_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    fault_valid_d    = 1'b0;
    fault_misalign_d = fault_misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = store_data;
          rd_d         = rd_addr;
          // Rejected ops report a fault and never touch memory.
          if (f3_illegal(is_store, funct3)) begin
            fault_valid_d    = 1'b1;
            fault_misalign_d = 1'b0;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            fault_valid_d    = 1'b1;
            fault_misalign_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (dmem_resp_valid) begin
          state_d = ST_IDLE;
          if (!is_store_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      is_store_q       <= 1'b0;
      funct3_q         <= '0;
      addr_q           <= '0;
      store_data_q     <= '0;
      rd_q             <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      fault_valid_q    <= 1'b0;
      fault_misalign_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      is_store_q       <= is_store_d;
      funct3_q         <= funct3_d;
      addr_q           <= addr_d;
      store_data_q     <= store_data_d;
      rd_q             <= rd_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      fault_valid_q    <= fault_valid_d;
      fault_misalign_q <= fault_misalign_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_we        = is_store_q;
  assign dmem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wstrb     = lane_wstrb;
  assign dmem_wdata     = lane_wdata;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign fault_valid    = fault_valid_q;
  assign fault_misalign = fault_misalign_q;
  assign dbg_state      = state_q;

endmodule
